// File: rtl/tpu_pkg.sv
// tpu_pkg: shared weight format and feeder state encoding
package tpu_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_BITS = 8;
  typedef logic [DATA_W-1:0] weight_t;
  typedef enum logic [1:0] {FILL, SHIFT, SWITCH} feeder_state_e;
endpackage

// File: rtl/weight_tile_buf.sv
// weight_tile_buf: ROWS-deep register file of COLS-lane weight rows
module weight_tile_buf #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int DATA_W = 16,
  parameter int RW = ROWS > 1 ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [RW-1:0]            wr_row,
  input  logic [COLS*DATA_W-1:0]   wr_data,
  input  logic [RW-1:0]            rd_row,
  output logic [COLS*DATA_W-1:0]   rd_data
);
  logic [COLS*DATA_W-1:0] mem [ROWS];
  // contents need no reset; a tile is always fully written before it is read
  always_ff @(posedge clk)
    if (we) mem[wr_row] <= wr_data;
  assign rd_data = mem[rd_row];
endmodule

// File: rtl/systolic_weight_feeder.sv
// systolic_weight_feeder: buffers a weight tile and shifts it into the array north edge; WEIGHT_FEEDER_PREFETCH_EN adds a second tile buffer
module systolic_weight_feeder
  import tpu_pkg::*;
#(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int DATA_W = tpu_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COLS*DATA_W-1:0] in_data,
  input  logic                   sw_allow,
  output logic [COLS*DATA_W-1:0] weight_out,
  output logic [COLS-1:0]        accept_w_out,
  output logic                   switch_out,
  output logic                   busy,
  output logic                   tile_done
);
  localparam int W = COLS * DATA_W;
  localparam int CW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

  feeder_state_e state, nstate;
  logic [CW-1:0] scnt, n_scnt, wcnt, n_wcnt, rd_row;
  logic [W-1:0] n_w, rd_data;
  logic [COLS-1:0] n_acc_w;
  logic acc, last, n_rdy, pf_go, pf_byp;

  assign acc = in_valid && in_ready;
  assign last = acc && wcnt == LAST;
  assign n_wcnt = acc ? (last ? '0 : wcnt + CW'(1)) : wcnt;
  assign rd_row = state == SHIFT ? scnt - CW'(1) : LAST;
  assign switch_out = state == SWITCH && sw_allow;
  assign tile_done = switch_out;

`ifdef WEIGHT_FEEDER_PREFETCH_EN
  logic wb, rb, n_wb;
  logic [1:0] full, n_full;
  logic [W-1:0] rd0, rd1;
  weight_tile_buf #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .RW(CW)) u_buf0 (
    .clk(clk), .we(acc && !wb), .wr_row(wcnt), .wr_data(in_data), .rd_row(rd_row), .rd_data(rd0));
  weight_tile_buf #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .RW(CW)) u_buf1 (
    .clk(clk), .we(acc && wb), .wr_row(wcnt), .wr_data(in_data), .rd_row(rd_row), .rd_data(rd1));
  assign rd_data = ((state == SWITCH) ? !rb : rb) ? rd1 : rd0;
  assign pf_byp = last && wb != rb;
  assign pf_go = full[!rb] || pf_byp;
  assign n_wb = wb ^ last;
  assign n_rdy = !n_full[n_wb];
  // tile bookkeeping: completed fills mark a buffer full, a switch releases the shifted one
  always_comb begin
    n_full = full;
    if (last) n_full[wb] = 1'b1;
    if (switch_out) n_full[rb] = 1'b0;
  end
  // ping-pong pointers for the filling and the shifting buffer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full <= '0;
      wb <= 1'b0;
      rb <= 1'b0;
    end else begin
      full <= n_full;
      wb <= n_wb;
      rb <= rb ^ switch_out;
    end
`else
  weight_tile_buf #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .RW(CW)) u_buf (
    .clk(clk), .we(acc), .wr_row(wcnt), .wr_data(in_data), .rd_row(rd_row), .rd_data(rd_data));
  assign pf_go = 1'b0;
  assign pf_byp = 1'b0;
  assign n_rdy = nstate == FILL;
`endif

  // next state and next registered outputs; the last beat of a tile bypasses the buffer
  always_comb begin
    nstate = state;
    n_scnt = scnt;
    n_acc_w = '0;
    n_w = '0;
    if (state == FILL && last) begin
      nstate = SHIFT;
      n_scnt = LAST;
      n_acc_w = '1;
      n_w = in_data;
    end else if (state == SHIFT) begin
      nstate = scnt == '0 ? SWITCH : SHIFT;
      n_scnt = scnt - CW'(1);
      n_acc_w = scnt == '0 ? '0 : '1;
      n_w = scnt == '0 ? '0 : rd_data;
    end else if (switch_out) begin
      nstate = pf_go ? SHIFT : FILL;
      n_scnt = LAST;
      n_acc_w = {COLS{pf_go}};
      n_w = pf_go ? (pf_byp ? in_data : rd_data) : '0;
    end
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      scnt <= '0;
      wcnt <= '0;
      weight_out <= '0;
      accept_w_out <= '0;
      in_ready <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nstate;
      scnt <= n_scnt;
      wcnt <= n_wcnt;
      weight_out <= n_w;
      accept_w_out <= n_acc_w;
      in_ready <= n_rdy;
      busy <= !(nstate == FILL && n_wcnt == '0);
    end
endmodule

// File: tb/tb_systolic_weight_feeder.sv
// tb_systolic_weight_feeder: directed checks of the weight feeder (ROWS=2, COLS=2)
module tb_systolic_weight_feeder;
  import tpu_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sw_allow = 1'b0;
  logic [31:0] in_data = '0;
  logic in_ready, switch_out, busy, tile_done;
  logic [31:0] weight_out;
  logic [1:0] accept_w_out;
  int tests = 0, fails = 0;
  weight_t neg_w = 16'hFC9A;

  systolic_weight_feeder #(.ROWS(2), .COLS(2), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sw_allow(sw_allow), .weight_out(weight_out), .accept_w_out(accept_w_out),
    .switch_out(switch_out), .busy(busy), .tile_done(tile_done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_acc"}, 32'(accept_w_out), 32'h0);
    chk({tag, "_w"}, weight_out, 32'h0);
    chk({tag, "_sw"}, 32'(switch_out), 32'h0);
    chk({tag, "_td"}, 32'(tile_done), 32'h0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    nc(); nc();
    chk_idle("rst");
    rst_n = 1'b1;
    nc();
    chk("rst_rel_rdy", 32'(in_ready), 32'h1);
    chk("rst_rel_busy", 32'(busy), 32'h0);

    sw_allow = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h0200_0459;
    nc();
    chk("b_busy", 32'(busy), 32'h1);
    chk("b_acc0", 32'(accept_w_out), 32'h0);
    in_data = 32'h0A9A_05C0;
    nc();
    in_valid = 1'b0;
    chk("b_acc1", 32'(accept_w_out), 32'h3);
    chk("b_w1", weight_out, 32'h0A9A_05C0);
    chk("b_rdy1", 32'(in_ready), 32'h0);
    nc();
    chk("b_acc2", 32'(accept_w_out), 32'h3);
    chk("b_w2", weight_out, 32'h0200_0459);
    nc();
    chk("b_acc3", 32'(accept_w_out), 32'h0);
    chk("b_w3", weight_out, 32'h0);
    chk("b_sw", 32'(switch_out), 32'h1);
    chk("b_td", 32'(tile_done), 32'h1);
    nc();
    chk("b_sw_end", 32'(switch_out), 32'h0);
    chk("b_rdy_end", 32'(in_ready), 32'h1);
    chk("b_busy_end", 32'(busy), 32'h0);

    sw_allow = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h0200_0459;
    nc();
    in_data = 32'h0A9A_05C0;
    nc();
    in_valid = 1'b0;
    nc();
    for (int i = 0; i < 5; i++) begin
      nc();
      chk("g_sw_low", 32'(switch_out), 32'h0);
      chk("g_acc_low", 32'(accept_w_out), 32'h0);
    end
    sw_allow = 1'b1;
    #1;
    chk("g_sw", 32'(switch_out), 32'h1);
    chk("g_td", 32'(tile_done), 32'h1);
    nc();
    chk("g_sw_once", 32'(switch_out), 32'h0);
    chk("g_rdy", 32'(in_ready), 32'h1);

    sw_allow = 1'b0;
    in_valid = 1'b1;
    in_data = {16'h1234, neg_w};
    nc();
    in_valid = 1'b0;
    in_data = 32'hDEAD_BEEF;
    nc(); nc();
    in_valid = 1'b1;
    in_data = {neg_w, 16'h0001};
    nc();
    in_data = 32'h5555_AAAA;
    chk("s_acc1", 32'(accept_w_out), 32'h3);
    chk("s_w1", weight_out, 32'hFC9A_0001);
    nc();
    chk("s_acc2", 32'(accept_w_out), 32'h3);
    chk("s_w2", weight_out, 32'h1234_FC9A);
    chk("bp_rdy_shift", 32'(in_ready), 32'h0);
    nc();
    chk("bp_rdy_switch", 32'(in_ready), 32'h0);
    chk("bp_acc", 32'(accept_w_out), 32'h0);
    nc();
    sw_allow = 1'b1;
    #1;
    chk("bp_sw", 32'(switch_out), 32'h1);
    nc();
    chk("bp_rdy_fill", 32'(in_ready), 32'h1);
    chk("bp_busy_fill", 32'(busy), 32'h0);
    nc();
    chk("bp_busy_held", 32'(busy), 32'h1);
    in_data = 32'h0101_0202;
    nc();
    in_valid = 1'b0;
    chk("bp_w1", weight_out, 32'h0101_0202);
    nc();
    chk("bp_w2", weight_out, 32'h5555_AAAA);
    nc();
    chk("bp_sw2", 32'(switch_out), 32'h1);
    nc();

    in_valid = 1'b1;
    in_data = 32'h1111_2222;
    nc();
    in_data = 32'h3333_4444;
    nc();
    in_valid = 1'b0;
    chk("r_acc_pre", 32'(accept_w_out), 32'h3);
    rst_n = 1'b0;
    #1;
    chk_idle("r_mid");
    nc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nc();
      chk("r_no_sw", 32'(switch_out), 32'h0);
      chk("r_no_acc", 32'(accept_w_out), 32'h0);
    end
    in_valid = 1'b1;
    in_data = 32'h0007_0008;
    nc();
    in_data = 32'h0009_000A;
    nc();
    in_valid = 1'b0;
    chk("r_w1", weight_out, 32'h0009_000A);
    nc();
    chk("r_w2", weight_out, 32'h0007_0008);
    nc();
    chk("r_sw", 32'(switch_out), 32'h1);
    nc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
